// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: shares one resource among N requesters.
// A one-hot ring pointer marks the highest-priority requester; it rotates
// past each served requester on release. The grant is registered, one-hot,
// and held until the owner signals done or the hold timeout expires.
module rr_grant_scheduler #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N-1:0]                        req,
    input  logic                                done,
    output logic [N-1:0]                        grant,
    output logic                                grant_valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
    output logic                                timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    // Hold counter must be able to hold MAX_HOLD; keep at least one bit when disabled.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_idx_q, grant_idx_d;
    logic            grant_valid_q, grant_valid_d;
    logic            timeout_q, timeout_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

    // Arbitration datapath
    logic [N-1:0]    upper_req;
    logic [N-1:0]    pick_src;
    logic [N-1:0]    sel_onehot;
    logic [IW-1:0]   sel_idx;
    logic            hold_expired;
    logic [N-1:0]    idx_mask [IW];

    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    always_comb begin
        upper_req  = req & ~(ptr_q - N'(1));
        pick_src   = (|upper_req) ? upper_req : req;
        sel_onehot = pick_src & (~pick_src + N'(1));
    end

    // One-hot to binary encoder: index bit gi is the OR of all positions whose index has bit gi set.
    generate
        for (genvar gi = 0; gi < IW; gi++) begin : g_enc
            for (genvar gj = 0; gj < N; gj++) begin : g_mask
                assign idx_mask[gi][gj] = 1'((gj >> gi) & 1);
            end
            assign sel_idx[gi] = |(sel_onehot & idx_mask[gi]);
        end
    endgenerate

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD));

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d       = sel_onehot;
                    grant_idx_d   = sel_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = HW'(1);
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (done || hold_expired) begin
                    // done wins over a coincident timeout, so timeout only pulses without done.
                    timeout_d     = ~done;
                    ptr_d         = {grant_q[N-2:0], grant_q[N-1]};
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    state_d       = IDLE;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= N'(1);
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign timeout     = timeout_q;

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one resource among N requesters.
- Priority is held in an internal one-hot ring pointer that rotates past each served requester.
- Grant is one-hot, registered, and held until the owner signals done or a hold-timeout fires.
- Sits between requesting blocks and the shared datapath; downstream muxing uses grant or grant_idx.

Parameters:
- N, 8, number of requesters (N >= 2).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release. 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N  request bits, one per requester, sampled every edge.
- done  in  1  current owner releases the resource. Sampled only while granting.
- grant  out  N  one-hot grant, or all zero when idle.
- grant_valid  out  1  high while grant is nonzero.
- grant_idx  out  $clog2(N)  binary index of the granted bit. 0 when idle.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values, applied at the edge where reset=1:
  - grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - Pointer = one-hot bit 0 (00...01).
  - State = IDLE, hold counter = 0.
- Reset overrides everything, including mid-grant: grant drops after that edge and the pointer returns to bit 0.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at an edge, select the first set req bit at or above the pointer position, searching upward with wrap from N-1 to 0.
  - After that edge: grant = selected bit, grant_idx = its index, grant_valid=1, hold counter=1, state=GRANT. Latency is 1 cycle from req sampled to grant visible.
  - If req == 0, stay in IDLE. done is ignored in IDLE.
- GRANT:
  - grant, grant_idx and grant_valid stay stable. Changes on req (including the owner dropping its req) are ignored.
  - If done=1 at an edge:
    - After the edge: grant=0, grant_valid=0, grant_idx=0, state=IDLE.
    - Pointer = granted bit rotated left by one (bit N-1 wraps to bit 0).
  - Else if MAX_HOLD != 0 and hold counter == MAX_HOLD at an edge:
    - Same release and pointer update as done.
    - timeout=1 for exactly the following cycle.
  - Otherwise the hold counter increments. It saturates and never wraps.
  - done and timeout both eligible on the same edge: done takes priority and timeout stays 0.
- Grants never overlap. Every release is followed by at least one IDLE cycle (grant=0) before the next grant.
- A continuously requesting set is therefore served in strict ring order. Each grant lasts at most MAX_HOLD cycles.
- The pointer is always exactly one-hot. It changes only on release or reset.
- Invariants checked by the bench:
  - $onehot0(grant).
  - grant_valid == |grant.
  - grant_idx matches grant.
  - timeout is never high in two consecutive cycles.

Test Plan (N=8, MAX_HOLD=16):
1. Reset and first grant:
   - Stimulus: reset=1 for 2 edges with req=8'hFF.
   - Response: grant=00000000 in both cycles. After the first edge with reset=0, grant=00000001, grant_idx=0.
2. Full rotation:
   - Stimulus: req=8'hFF held, done pulsed for one cycle during every grant.
   - Response: grants are 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000, then 00000001 again (wrap). Each grant is separated by one grant=0 cycle.
3. Skip and wrap:
   - Stimulus: after serving bit 0 (pointer at bit 1), req=10000001.
   - Response: grant=10000000 first. After done, grant=00000001.
4. Timeout:
   - Stimulus: req=00000100, done=0.
   - Response: grant=00000100 for exactly 16 cycles, then grant=0 with timeout=1 for one cycle. A following req=00001100 gets grant=00001000.
5. Reset mid-grant:
   - Stimulus: while grant=00010000, assert reset for one edge with req=8'hFF.
   - Response: grant=0 after that edge. After reset releases, grant=00000001.
6. Ignored inputs:
   - Stimulus: done=1 while idle with req=0, then req=00000010 dropped mid-grant.
   - Response: done in idle has no effect. grant=00000010 is held until done. A done and timeout coincident on cycle 16 gives timeout=0.
